// File: rtl/fas_stream_checker.sv
// Multi-lane stream checker: compares DUT output beats against golden data with an
// optional +/-TOL window, counts lane errors, reports per block and aborts on a fail limit.
module fas_stream_checker #(
    parameter int unsigned LANES       = 16,
    parameter int unsigned COMPS       = 2,
    parameter int unsigned CW          = 16,
    parameter int unsigned TOL         = 3,
    parameter int unsigned BLOCK_LEN   = 16,
    parameter int unsigned TOTAL_BEATS = 64,
    parameter int unsigned FAIL_LIMIT  = 48,
    localparam int unsigned DW  = LANES * COMPS * CW,
    localparam int unsigned ECW = $clog2(LANES * TOTAL_BEATS + 1),
    localparam int unsigned BCW = $clog2(TOTAL_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             act_valid,
    input  logic [DW-1:0]    act_data,
    input  logic [DW-1:0]    exp_data,
    output logic [LANES-1:0] lane_err,
    output logic [ECW-1:0]   err_cnt,
    output logic [BCW-1:0]   beat_cnt,
    output logic             block_done,
    output logic             block_pass,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    localparam int unsigned PW  = $clog2(LANES + 1);
    localparam int unsigned BLW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t           state;
    logic             mode_q;
    logic [BLW-1:0]   blk_cnt;
    logic             blk_flag;

    logic [LANES-1:0] lane_err_nx;
    logic [PW-1:0]    pop;
    logic [ECW:0]     err_sum;
    logic [ECW-1:0]   err_nx;
    logic [BCW-1:0]   beat_nx;
    logic             blk_end;
    logic             limit_hit;
    logic             last_beat;
    logic [CW-1:0]    d;
    logic [CW-1:0]    d_neg;

    // Per-component modular difference; the window test uses |d| in both directions so wrap-around matches
    always_comb begin
        lane_err_nx = '0;
        d           = '0;
        d_neg       = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            for (int c = 0; c < int'(COMPS); c++) begin
                d     = exp_data[(l*COMPS+c)*CW +: CW] - act_data[(l*COMPS+c)*CW +: CW];
                d_neg = CW'(0) - d;
                if (mode_q) begin
                    if ((d > CW'(TOL)) && (d_neg > CW'(TOL))) lane_err_nx[l] = 1'b1;
                end else begin
                    if (d != '0) lane_err_nx[l] = 1'b1;
                end
            end
        end
    end

    // Error accumulation with saturation, beat/block bookkeeping
    always_comb begin
        pop = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            pop = pop + PW'(lane_err_nx[l]);
        end
        err_sum   = {1'b0, err_cnt} + (ECW+1)'(pop);
        err_nx    = err_sum[ECW] ? '1 : err_sum[ECW-1:0];
        beat_nx   = beat_cnt + BCW'(1);
        blk_end   = (blk_cnt == BLW'(BLOCK_LEN - 1));
        limit_hit = (err_nx >= ECW'(FAIL_LIMIT));
        last_beat = (beat_nx == BCW'(TOTAL_BEATS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            blk_cnt    <= '0;
            blk_flag   <= 1'b0;
            lane_err   <= '0;
            err_cnt    <= '0;
            beat_cnt   <= '0;
            block_done <= 1'b0;
            block_pass <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            block_done <= 1'b0;
            if (start) begin
                state      <= RUN;
                mode_q     <= mode;
                blk_cnt    <= '0;
                blk_flag   <= 1'b0;
                lane_err   <= '0;
                err_cnt    <= '0;
                beat_cnt   <= '0;
                block_pass <= 1'b0;
                done       <= 1'b0;
                pass       <= 1'b0;
                fail       <= 1'b0;
            end else if (state == RUN && act_valid) begin
                lane_err <= lane_err_nx;
                beat_cnt <= beat_nx;
                err_cnt  <= err_nx;
                if (blk_end) begin
                    block_done <= 1'b1;
                    block_pass <= !(blk_flag || (|lane_err_nx));
                    blk_flag   <= 1'b0;
                    blk_cnt    <= '0;
                end else begin
                    blk_flag   <= blk_flag || (|lane_err_nx);
                    blk_cnt    <= blk_cnt + BLW'(1);
                end
                // Abort takes priority over normal completion
                if (limit_hit) begin
                    state <= FAIL;
                    done  <= 1'b1;
                    fail  <= 1'b1;
                end else if (last_beat) begin
                    done <= 1'b1;
                    if (err_nx == '0) begin
                        state <= PASS;
                        pass  <= 1'b1;
                    end else begin
                        state <= FAIL;
                        fail  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/fas_stream_checker.md
Name: fas_stream_checker

Overview:
- Synthesizable, parametrised successor to the FAS output checking: compares a multi-lane DUT output stream (FIR samples or FFT bins) against an expected stream, using a per-component ±tolerance window.
- Counts mismatches, reports pass/fail per block of beats, and aborts on a fail limit.
- Sits beside FAS on the FPGA/emulation build. Expected data comes from a golden ROM, so self-check runs without the simulator.

Parameters:
- LANES, 16, lanes compared per beat (16 for FFT bins, 1 for FIR).
- COMPS, 2, components per lane (2 = real/imag, 1 = scalar).
- CW, 16, component width in bits.
- TOL, 3, maximum absolute modular difference accepted per component in tolerance mode.
- BLOCK_LEN, 16, beats per block report.
- TOTAL_BEATS, 64, beats per run.
- FAIL_LIMIT, 48, lane-error count that aborts the run.
- Derived: DW = LANES\*COMPS\*CW; ECW = clog2(LANES\*TOTAL_BEATS+1); BCW = clog2(TOTAL_BEATS+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; clears counters and enters RUN.
- mode  in  1  0 = exact compare, 1 = ±TOL compare; sampled on start.
- act_valid  in  1  act_data/exp_data beat valid.
- act_data  in  DW  DUT output. Lane n, component c occupies bits [(n\*COMPS+c)\*CW +: CW]; component COMPS-1 is real.
- exp_data  in  DW  golden data, same packing.
- lane_err  out  LANES  per-lane mismatch flags for the last accepted beat.
- err_cnt  out  ECW  total failing lanes this run.
- beat_cnt  out  BCW  beats accepted this run.
- block_done  out  1  one-cycle pulse at the end of each BLOCK_LEN-beat block.
- block_pass  out  1  valid with block_done; 1 if the block had zero lane errors.
- done  out  1  run finished; held.
- pass  out  1  held with done; 1 if err_cnt == 0 and all TOTAL_BEATS beats were checked.
- fail  out  1  held with done; 1 on fail-limit abort or on a run ending with errors.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, all counters 0, stored mode 0.
- States: IDLE, RUN, PASS, FAIL.
  - start in any state: go to RUN, clear counters, lane_err, done, pass, fail; latch mode. A beat presented in the same cycle as start is ignored.
- Component compare:
  - d = (exp - act) mod 2^CW.
  - Match if d == 0 (mode 0), or if d <= TOL or d >= 2^CW - TOL (mode 1).
  - Wrap-around is intended: exp 16'h0000 vs act 16'hFFFE matches in mode 1.
  - A lane errs if any of its components mismatches.
- RUN, act_valid=1 at edge t. All of the following register at t+1 (single-cycle latency):
  - lane_err updates.
  - beat_cnt increments.
  - err_cnt += popcount(lane_err_next), saturating at 2^ECW-1.
  - A block-error flag accumulates.
- Block report: when beat_cnt_next is a multiple of BLOCK_LEN, block_done=1 for one cycle and block_pass = !(block flag | any lane_err_next). The block flag then clears.
- Fail limit: if err_cnt_next >= FAIL_LIMIT, go to FAIL at t+1 with done=1, fail=1. If this is also a block boundary, block_done still pulses.
- Completion: when beat_cnt_next == TOTAL_BEATS and the limit is not hit:
  - go to PASS (done=1, pass=1) if err_cnt_next == 0;
  - otherwise go to FAIL (done=1, fail=1).
- act_valid=0 in RUN: no change. act_valid in IDLE/PASS/FAIL: ignored; outputs hold.
- pass and fail are never both 1. done stays 1 until start or reset.

Test Plan:
- Defaults, mode 1, 64 beats with act == exp → block_done pulses at beats 16/32/48/64 with block_pass=1; then done=1, pass=1, err_cnt=0, beat_cnt=64.
- Mode 1, lane 5 imag off by +3 on beat 2 and real off by -4 on beat 20 → beat 2 passes; beat 20 gives lane_err=16'h0020, err_cnt=1. Block 2 reports block_pass=0, the others 1. End state: done=1, fail=1.
- Mode 0, single component off by 1 → lane flagged, err_cnt=1. The same beat in mode 1 is not flagged.
- Mode 1, all 16 lanes failing on beats 0..2 → err_cnt 16, 32, then 48 at the third beat; state FAIL with fail=1, done=1, beat_cnt=3. A further act_valid leaves err_cnt at 48.
- Mode 1, exp=16'h0001 vs act=16'hFFFE (d=3) → match; exp=16'h0002 vs act=16'hFFFE (d=4) → error.
- Drive rst=0 mid-run at beat 10 → outputs 0 immediately, asynchronously. After rst=1 and start, the run restarts from beat_cnt=0.
